// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result buffer: op codes, compare codes,
// the stored entry layout and the encoding-check helper.
package alu_pkg;

  localparam logic [1:0] OP_TOPLA       = 2'b00;
  localparam logic [1:0] OP_CIKAR       = 2'b01;
  localparam logic [1:0] OP_KARE        = 2'b10;
  localparam logic [1:0] OP_KARSILASTIR = 2'b11;

  localparam logic [2:0] CMP_ESIT  = 3'b100;
  localparam logic [2:0] CMP_BUYUK = 3'b010;
  localparam logic [2:0] CMP_KUCUK = 3'b001;

  localparam logic [7:0] KARE_MAX = 8'd225;
  localparam int unsigned GIRIS_W = 12;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] sonuc;
    logic       sifir;
    logic       tasma;
  } giris_t;

  // True when the ALU bus carries bits the selected operation can never produce.
  function automatic logic kodlama_hatali(input logic [1:0] sel, input logic [7:0] sonuc);
    logic hatali;
    hatali = 1'b0;
    case (sel)
      OP_TOPLA, OP_CIKAR: hatali = (sonuc[7:5] != 3'b000);
      OP_KARE:            hatali = (sonuc > KARE_MAX);
      default:            hatali = (sonuc[7:3] != 5'b00000) ||
                                   !((sonuc[2:0] == CMP_ESIT) ||
                                     (sonuc[2:0] == CMP_BUYUK) ||
                                     (sonuc[2:0] == CMP_KUCUK));
    endcase
    return hatali;
  endfunction

endpackage

// File: rtl/sonuc_fifo.sv
// DEPTH x WIDTH synchronous FIFO with count output; storage is cleared on reset
// so the head read is always defined.
module sonuc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  // Handshake: a beat transfers on an edge where valid && ready; ready and
  // valid come only from the registered count, never from the other side.
  assign in_ready_o  = (count_q != FULL);
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/alu_sonuc_tamponu.sv
// Registered buffer behind the combinational ALU: derives zero/carry flags,
// checks result encoding, queues entries and keeps sticky error and push count.
module alu_sonuc_tamponu
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_sel,
  input  logic [7:0]             in_sonuc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_sel,
  output logic [7:0]             out_sonuc,
  output logic                   out_sifir,
  output logic                   out_tasma,
  output logic [$clog2(DEPTH):0] doluluk,
  output logic [7:0]             sayac,
  output logic                   hata
);

  giris_t     giris, cikis;
  logic       push;
  logic [7:0] sayac_q, sayac_d;
  logic       hata_q, hata_d;

  always_comb begin
    giris       = '0;
    giris.sel   = in_sel;
    giris.sonuc = in_sonuc;
    giris.sifir = (in_sonuc == 8'h00);
    // Bit 4 is the carry out of a 4-bit add, or the borrow of a 4-bit subtract.
    giris.tasma = ((in_sel == OP_TOPLA) || (in_sel == OP_CIKAR)) ? in_sonuc[4] : 1'b0;
  end

  sonuc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (GIRIS_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (giris),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (cikis),
    .count_o     (doluluk)
  );

  assign push = in_valid && in_ready;

  always_comb begin
    sayac_d = sayac_q;
    hata_d  = hata_q;
    if (push) begin
      if (sayac_q != 8'hFF) sayac_d = sayac_q + 8'd1;
      if (kodlama_hatali(in_sel, in_sonuc)) hata_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sayac_q <= 8'h00;
      hata_q  <= 1'b0;
    end else begin
      sayac_q <= sayac_d;
      hata_q  <= hata_d;
    end
  end

  assign out_sel   = cikis.sel;
  assign out_sonuc = cikis.sonuc;
  assign out_sifir = cikis.sifir;
  assign out_tasma = cikis.tasma;
  assign sayac     = sayac_q;
  assign hata      = hata_q;

endmodule

// File: tb/tb_alu_sonuc_tamponu.sv
// Directed bench for alu_sonuc_tamponu with an expected-entry queue for FIFO order.
module tb_alu_sonuc_tamponu;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic [7:0] in_sonuc;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sel;
  logic [7:0] out_sonuc;
  logic       out_sifir;
  logic       out_tasma;
  logic [2:0] doluluk;
  logic [7:0] sayac;
  logic       hata;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  int sayac_m = 0;

  alu_sonuc_tamponu #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_sonuc  (in_sonuc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_sonuc (out_sonuc),
    .out_sifir (out_sifir),
    .out_tasma (out_tasma),
    .doluluk   (doluluk),
    .sayac     (sayac),
    .hata      (hata)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] beklenen(input logic [1:0] s, input logic [7:0] d);
    logic t;
    t = (s == 2'b00 || s == 2'b01) ? d[4] : 1'b0;
    return {s, d, (d == 8'h00), t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1;
    in_valid = v; in_sel = 2'b00; in_sonuc = 8'h55; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    sayac_m = 0;
  endtask

  // One cycle: drive inputs, compare head against the queue, then advance the model.
  task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d, input logic ordy);
    bit acc, pp;
    in_valid = v; in_sel = s; in_sonuc = d; out_ready = ordy;
    acc = v && (exp_q.size() != DEPTH);
    pp  = (exp_q.size() != 0) && ordy;
    check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("head", 32'({out_sel, out_sonuc, out_sifir, out_tasma}), 32'(exp_q[0]));
    tick();
    if (pp) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(beklenen(s, d));
      if (sayac_m != 255) sayac_m++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("doluluk", 32'(doluluk), 32'(exp_q.size()));
    check("sayac", 32'(sayac), 32'(sayac_m));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_sonuc = 8'h00; out_ready = 1'b0;
    tick();
    do_reset(1'b0);

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_doluluk", 32'(doluluk), 32'd0);
    check("rst_sayac", 32'(sayac), 32'd0);
    check("rst_hata", 32'(hata), 32'd0);
    check("rst_data", 32'({out_sel, out_sonuc, out_sifir, out_tasma}), 32'd0);

    // 9+9 = 0x12: carry set, not zero
    step(1'b1, 2'b00, 8'h12, 1'b0);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_sonuc", 32'(out_sonuc), 32'h12);
    check("add_tasma", 32'(out_tasma), 32'd1);
    check("add_sifir", 32'(out_sifir), 32'd0);
    check("add_doluluk", 32'(doluluk), 32'd1);

    step(1'b1, 2'b00, 8'h05, 1'b0);
    step(1'b1, 2'b01, 8'h1F, 1'b0);
    step(1'b1, 2'b10, 8'h40, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_doluluk", 32'(doluluk), 32'd4);
    step(1'b1, 2'b00, 8'h07, 1'b0);
    check("full_refuse_sayac", 32'(sayac), 32'd4);
    check("full_refuse_doluluk", 32'(doluluk), 32'd4);
    // Full: pop with a push attempt, only the pop happens.
    step(1'b1, 2'b00, 8'h07, 1'b1);
    check("full_pop_doluluk", 32'(doluluk), 32'd3);
    step(1'b1, 2'b01, 8'h03, 1'b1);
    check("pushpop_doluluk", 32'(doluluk), 32'd3);
    step(1'b1, 2'b11, 8'h04, 1'b0);
    check("wrap_doluluk", 32'(doluluk), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 8'h00, 1'b1);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("legal_hata", 32'(hata), 32'd0);

    // Compare code 011 is not one-hot
    step(1'b1, 2'b11, 8'h03, 1'b0);
    check("cmp_hata", 32'(hata), 32'd1);
    check("cmp_sonuc", 32'(out_sonuc), 32'h03);
    step(1'b0, 2'b00, 8'h00, 1'b1);
    check("cmp_hata_sticky", 32'(hata), 32'd1);
    do_reset(1'b0);
    check("hata_cleared", 32'(hata), 32'd0);

    // 5-5 = 0
    step(1'b1, 2'b01, 8'h00, 1'b0);
    check("sub_sifir", 32'(out_sifir), 32'd1);
    check("sub_tasma", 32'(out_tasma), 32'd0);
    step(1'b1, 2'b10, 8'hE1, 1'b0);
    check("kare_max_hata", 32'(hata), 32'd0);
    step(1'b1, 2'b10, 8'hE2, 1'b0);
    check("kare_over_hata", 32'(hata), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 8'h00, 1'b1);

    do_reset(1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 2'b00, 8'($urandom_range(0, 31)), 1'b1);
    check("sayac_sat", 32'(sayac), 32'd255);
    step(1'b0, 2'b00, 8'h00, 1'b1);
    step(1'b1, 2'b00, 8'h01, 1'b0);
    step(1'b1, 2'b00, 8'h02, 1'b0);
    check("pre_rst_doluluk", 32'(doluluk), 32'd2);
    do_reset(1'b1);
    check("mid_rst_doluluk", 32'(doluluk), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sayac", 32'(sayac), 32'd0);
    check("mid_rst_data", 32'({out_sel, out_sonuc, out_sifir, out_tasma}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
